// File: rtl/boot_memory_pkg.sv
// rtl/boot_memory_pkg.sv - shared types and constants for the boot memory loader
package boot_memory_pkg;

  // Loader FSM: wait for a start, read the two header bytes, then stream data bytes.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEN_LO = 2'd1,
    ST_LEN_HI = 2'd2,
    ST_DATA   = 2'd3
  } load_state_e;

  // Image header is a 16-bit little-endian word count.
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Little-endian word assembly: the three earlier bytes sit in the low 24 bits.
  function automatic logic [31:0] assemble_word(input logic [23:0] low_bytes,
                                                input logic [7:0]  top_byte);
    return {top_byte, low_bytes};
  endfunction

endpackage

// File: rtl/boot_memory_if.sv
// rtl/boot_memory_if.sv - fetch port and image-loader port of the boot memory
interface boot_memory_if;
  logic [31:0] mem_address;
  logic        mem_read_strobe;
  logic [31:0] mem_read_data;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_error;
  logic        cpu_reset;

  // Master: processor fetch side plus the byte source that feeds the loader.
  modport master (
    output mem_address, mem_read_strobe, load_start, load_valid, load_byte,
    input  mem_read_data, load_ready, load_error, cpu_reset
  );

  // Slave: the boot memory itself.
  modport slave (
    input  mem_address, mem_read_strobe, load_start, load_valid, load_byte,
    output mem_read_data, load_ready, load_error, cpu_reset
  );
endinterface

// File: rtl/boot_memory_ram.sv
// rtl/boot_memory_ram.sv - single-clock word RAM, one write port, one registered read port
module sync_word_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter     INIT_FILE  = ""
) (
  input  logic                  CLK,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [31:0]           rd_data_o
);

  logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];

  // Write port; contents are never cleared by reset.
  always_ff @(posedge CLK) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read port: loads on enable, holds otherwise, sees pre-write data on collision.
  always_ff @(posedge CLK) begin
    if (rst_i)     rd_data_o <= 32'd0;
    else if (re_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/boot_memory.sv
// rtl/boot_memory.sv - instruction memory with byte-stream image loader and processor reset hold
module boot_memory
  import boot_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter     INIT_FILE  = ""
) (
  input  logic          CLK,
  input  logic          reset,
  boot_memory_if.slave  bus
);

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam int          BCW       = $clog2(BYTES_PER_WORD);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

  load_state_e      state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [23:0]      asm_q, asm_d;
  logic             load_error_q, load_error_d;
  logic             cpu_reset_q;

  logic             accept;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic [15:0]      hdr_count;
  logic             unused_addr_hi;

  // Upper address bits are deliberately ignored so the PC wraps modulo depth.
  assign unused_addr_hi = ^bus.mem_address[31:ADDR_WIDTH];

  // A start request takes priority, so a byte offered alongside it is dropped.
  assign accept    = (state_q != ST_IDLE) && bus.load_valid && !bus.load_start;
  assign hdr_count = {bus.load_byte, count_q[7:0]};
  assign wr_data   = assemble_word(asm_q, bus.load_byte);

  // Loader next-state, counters, byte assembler and write strobe.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    load_error_d = load_error_q;
    wr_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_LEN_LO: begin
        if (accept) begin
          count_d[7:0] = bus.load_byte;
          state_d      = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          count_d[15:8] = bus.load_byte;
          word_cnt_d    = 16'd0;
          byte_cnt_d    = '0;
          state_d       = (hdr_count == 16'd0) ? ST_IDLE : ST_DATA;
          if ({1'b0, hdr_count} > 17'(DEPTH)) load_error_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (byte_cnt_q == LAST_BYTE) begin
            // Words beyond the array are consumed but not stored.
            wr_en      = ({1'b0, word_cnt_q} < 17'(DEPTH));
            word_cnt_d = word_cnt_q + 16'd1;
            byte_cnt_d = '0;
            asm_d      = 24'd0;
            if ((word_cnt_q + 16'd1) == count_q) state_d = ST_IDLE;
          end else begin
            asm_d      = {bus.load_byte, asm_q[23:8]};
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Start (or restart) clears progress but leaves already-written words alone.
    if (bus.load_start) begin
      state_d      = ST_LEN_LO;
      count_d      = 16'd0;
      word_cnt_d   = 16'd0;
      byte_cnt_d   = '0;
      asm_d        = 24'd0;
      load_error_d = 1'b0;
    end
  end

  // Loader state register and processor reset hold.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= 16'd0;
      word_cnt_q   <= 16'd0;
      byte_cnt_q   <= '0;
      asm_q        <= 24'd0;
      load_error_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      load_error_q <= load_error_d;
      cpu_reset_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.load_ready = (state_q != ST_IDLE);
  assign bus.load_error = load_error_q;
  assign bus.cpu_reset  = cpu_reset_q;

  sync_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .CLK       (CLK),
    .rst_i     (reset),
    .we_i      (wr_en),
    .wr_addr_i (word_cnt_q[ADDR_WIDTH-1:0]),
    .wr_data_i (wr_data),
    .re_i      (bus.mem_read_strobe),
    .rd_addr_i (bus.mem_address[ADDR_WIDTH-1:0]),
    .rd_data_o (bus.mem_read_data)
  );

endmodule
